// File: rtl/tl45_muldiv_seq.sv
// tl45_muldiv_seq: multi-cycle unsigned MUL / DIVU / REMU unit for the execute stage.
// Runs alongside the single-cycle ALU and iterates one bit per cycle
// (shift-add multiply, restoring divide). It stalls upstream while it is
// busy, then retires one write-back and forward result.
module tl45_muldiv_seq #(
  parameter int         XLEN    = 32,
  parameter logic [4:0] OP_MUL  = 5'h3,
  parameter logic [4:0] OP_DIVU = 5'h4,
  parameter logic [4:0] OP_REMU = 5'h5
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_pipe_stall,
  input  logic            i_pipe_flush,
  input  logic [4:0]      i_opcode,
  input  logic [3:0]      i_dr,
  input  logic [XLEN-1:0] i_sr1_val,
  input  logic [XLEN-1:0] i_sr2_val,
  output logic            o_pipe_stall,
  output logic [3:0]      o_dr,
  output logic [XLEN-1:0] o_value,
  output logic [3:0]      o_of_reg,
  output logic [XLEN-1:0] o_of_val,
  output logic            o_busy
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       op_reg;
  logic [3:0]       dr_reg;
  // a_reg: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV/REM)
  // b_reg: multiplier (MUL) or divisor (DIV/REM)
  // acc_reg: product (MUL) or partial remainder (DIV/REM)
  logic [XLEN-1:0]  a_reg, b_reg, acc_reg;

  logic             is_muldiv;
  logic             accept;
  logic             retire;
  logic             last_iter;
  logic             op_is_mul;
  logic [XLEN-1:0]  result;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_diff;
  logic             div_ok;

  assign is_muldiv = (i_opcode == OP_MUL) || (i_opcode == OP_DIVU) || (i_opcode == OP_REMU);
  assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));
  assign op_is_mul = (op_reg == OP_MUL);
  assign o_busy    = (state_reg != IDLE);

  // Restoring-division trial subtract. The partial remainder always stays
  // below the divisor (or is built from dividend bits only when the divisor
  // is zero), so the extra top bit of the difference is a valid borrow flag.
  assign div_shift = {acc_reg, a_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_ok    = ~div_diff[XLEN];

  // The quotient accumulates in a_reg; product and remainder share acc_reg.
  assign result = (op_reg == OP_DIVU) ? a_reg : acc_reg;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, stall and forward outputs; a flush overrides everything
  always_comb begin
    state_next   = state_reg;
    o_pipe_stall = 1'b0;
    o_of_reg     = '0;
    o_of_val     = '0;
    accept       = 1'b0;
    retire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_muldiv) begin
          o_pipe_stall = 1'b1;
          accept       = 1'b1;
          state_next   = RUN;
        end
      end
      RUN: begin
        o_pipe_stall = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_pipe_stall = i_pipe_stall;
        o_of_reg     = dr_reg;
        o_of_val     = result;
        if (!i_pipe_stall) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (i_pipe_flush) begin
      o_pipe_stall = 1'b0;
      o_of_reg     = '0;
      o_of_val     = '0;
      accept       = 1'b0;
      retire       = 1'b0;
      state_next   = IDLE;
    end
  end

  // Operand latch on accept, then one shift-add / shift-subtract step per RUN cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_reg <= '0;
      op_reg  <= '0;
      dr_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
      op_reg  <= i_opcode;
      dr_reg  <= i_dr;
      a_reg   <= i_sr1_val;
      b_reg   <= i_sr2_val;
      acc_reg <= '0;
    end else if (state_reg == RUN && !i_pipe_flush) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (op_is_mul) begin
        if (b_reg[0]) begin
          acc_reg <= acc_reg + a_reg;
        end
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
      end else begin
        acc_reg <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        a_reg   <= {a_reg[XLEN-2:0], div_ok};
      end
    end
  end

  // Write-back register: non-zero only in the single cycle after retirement
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dr    <= '0;
      o_value <= '0;
    end else if (retire) begin
      o_dr    <= dr_reg;
      o_value <= result;
    end else begin
      o_dr    <= '0;
      o_value <= '0;
    end
  end

endmodule

// File: tb/tb_tl45_muldiv_seq.sv
// Testbench for tl45_muldiv_seq: table-driven directed vectors, randomized
// operations against an arithmetic reference model, and hand-written
// flush / downstream-stall / reset sequences.
module tb_tl45_muldiv_seq;

  localparam int         XLEN    = 32;
  localparam logic [4:0] OP_NOP  = 5'h0;
  localparam logic [4:0] OP_ADD  = 5'h1;
  localparam logic [4:0] OP_MUL  = 5'h3;
  localparam logic [4:0] OP_DIVU = 5'h4;
  localparam logic [4:0] OP_REMU = 5'h5;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_pipe_stall;
  logic            i_pipe_flush;
  logic [4:0]      i_opcode;
  logic [3:0]      i_dr;
  logic [XLEN-1:0] i_sr1_val;
  logic [XLEN-1:0] i_sr2_val;
  logic            o_pipe_stall;
  logic [3:0]      o_dr;
  logic [XLEN-1:0] o_value;
  logic [3:0]      o_of_reg;
  logic [XLEN-1:0] o_of_val;
  logic            o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  dr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  tl45_muldiv_seq #(.XLEN(XLEN)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_pipe_stall (i_pipe_stall),
    .i_pipe_flush (i_pipe_flush),
    .i_opcode     (i_opcode),
    .i_dr         (i_dr),
    .i_sr1_val    (i_sr1_val),
    .i_sr2_val    (i_sr2_val),
    .o_pipe_stall (o_pipe_stall),
    .o_dr         (o_dr),
    .o_value      (o_value),
    .o_of_reg     (o_of_reg),
    .o_of_val     (o_of_val),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Unsigned arithmetic reference; divide by zero follows the restoring-divider result.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op == OP_MUL) begin
      p = 64'(a) * 64'(b);
      return p[31:0];
    end
    if (b == 32'd0) return (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
    return (op == OP_DIVU) ? (a / b) : (a % b);
  endfunction

  // Present an op at the current cycle start (unit idle) and follow it to write-back.
  // Returns in the write-back cycle with i_opcode set to NOP.
  task automatic run_op(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold, input string tag);
    int stall_cnt;
    int bad;
    i_opcode     = op;
    i_dr         = dr;
    i_sr1_val    = a;
    i_sr2_val    = b;
    i_pipe_stall = 1'b0;
    i_pipe_flush = 1'b0;
    #1;
    stall_cnt = o_pipe_stall ? 1 : 0;
    bad       = 0;
    check({tag, " accept_busy"}, 32'(o_busy), 32'd0);
    for (int c = 1; c <= XLEN; c++) begin
      tick();
      if (o_pipe_stall) stall_cnt++;
      if (o_dr != 4'd0 || o_value != 32'd0 || o_of_reg != 4'd0 || o_busy !== 1'b1) bad++;
    end
    check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(XLEN + 1));
    check({tag, " run_quiet"}, 32'(bad), 32'd0);
    for (int k = 0; k <= hold; k++) begin
      tick();
      i_pipe_stall = (k < hold);
      #1;
      check($sformatf("%s done%0d_of_reg", tag, k), 32'(o_of_reg), 32'(dr));
      check($sformatf("%s done%0d_of_val", tag, k), o_of_val, exp);
      check($sformatf("%s done%0d_stall", tag, k), 32'(o_pipe_stall), 32'(i_pipe_stall));
      check($sformatf("%s done%0d_dr", tag, k), 32'(o_dr), 32'd0);
    end
    tick();
    i_opcode     = OP_NOP;
    i_pipe_stall = 1'b0;
    #1;
    check({tag, " wb_dr"}, 32'(o_dr), 32'(dr));
    check({tag, " wb_value"}, o_value, exp);
    check({tag, " wb_busy"}, 32'(o_busy), 32'd0);
    check({tag, " wb_stall"}, 32'(o_pipe_stall), 32'd0);
    check({tag, " wb_of_reg"}, 32'(o_of_reg), 32'd0);
    $display("txn %s op=%0h dr=%0d a=%08h b=%08h hold=%0d -> value=%08h (expect %08h)",
             tag, op, dr, a, b, hold, o_value, exp);
  endtask

  initial begin
    int bad;
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [3:0]  r_dr;

    vecs[0]  = '{OP_MUL,  4'd3,  32'd7,          32'd6,          32'd42,         0};
    vecs[1]  = '{OP_MUL,  4'd1,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  0};
    vecs[2]  = '{OP_DIVU, 4'd2,  32'd100,        32'd7,          32'd14,         0};
    vecs[3]  = '{OP_REMU, 4'd4,  32'd100,        32'd7,          32'd2,          3};
    vecs[4]  = '{OP_DIVU, 4'd5,  32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[5]  = '{OP_REMU, 4'd6,  32'd5,          32'd0,          32'd5,          0};
    vecs[6]  = '{OP_MUL,  4'd7,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          0};
    vecs[7]  = '{OP_MUL,  4'd8,  32'h0001_0000,  32'h0001_0000,  32'd0,          1};
    vecs[8]  = '{OP_DIVU, 4'd9,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  0};
    vecs[9]  = '{OP_REMU, 4'd10, 32'hFFFF_FFFF,  32'h10,         32'hF,          0};
    vecs[10] = '{OP_DIVU, 4'd11, 32'd7,          32'd100,        32'd0,          2};

    i_reset_n    = 1'b0;
    i_pipe_stall = 1'b0;
    i_pipe_flush = 1'b0;
    i_opcode     = OP_NOP;
    i_dr         = 4'd0;
    i_sr1_val    = 32'd0;
    i_sr2_val    = 32'd0;
    tick();
    tick();
    check("reset o_dr", 32'(o_dr), 32'd0);
    check("reset o_value", o_value, 32'd0);
    check("reset o_pipe_stall", 32'(o_pipe_stall), 32'd0);
    check("reset o_of_reg", 32'(o_of_reg), 32'd0);
    check("reset o_of_val", o_of_val, 32'd0);
    check("reset o_busy", 32'(o_busy), 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Directed table, issued back to back
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].dr, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold,
             $sformatf("vec%0d", i));
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0:       r_op = OP_MUL;
        1:       r_op = OP_DIVU;
        default: r_op = OP_REMU;
      endcase
      r_a = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 255));
        default: r_b = $urandom;
      endcase
      r_dr = 4'($urandom_range(1, 15));
      run_op(r_op, r_dr, r_a, r_b, ref_model(r_op, r_a, r_b), int'($urandom_range(0, 2)),
             $sformatf("rnd%0d", i));
    end
    tick();
    check("post_idle o_dr", 32'(o_dr), 32'd0);

    // Muldiv op presented with a flush is not accepted
    i_opcode = OP_MUL; i_dr = 4'd3; i_sr1_val = 32'd9; i_sr2_val = 32'd9; i_pipe_flush = 1'b1;
    #1;
    check("flush_accept stall", 32'(o_pipe_stall), 32'd0);
    tick();
    i_pipe_flush = 1'b0;
    i_opcode     = OP_NOP;
    #1;
    check("flush_accept busy", 32'(o_busy), 32'd0);
    $display("txn flush_on_accept");

    // Flush in RUN cycle 10: no write-back, no forward ever
    i_opcode = OP_MUL; i_dr = 4'd12; i_sr1_val = 32'd7; i_sr2_val = 32'd6;
    #1;
    check("flush_run accept_stall", 32'(o_pipe_stall), 32'd1);
    for (int c = 1; c <= 10; c++) tick();
    i_pipe_flush = 1'b1;
    #1;
    check("flush_run stall", 32'(o_pipe_stall), 32'd0);
    tick();
    i_pipe_flush = 1'b0;
    i_opcode     = OP_NOP;
    #1;
    check("flush_run busy", 32'(o_busy), 32'd0);
    check("flush_run idle_stall", 32'(o_pipe_stall), 32'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_dr != 4'd0 || o_of_reg != 4'd0 || o_busy != 1'b0) bad++;
    end
    check("flush_run no_writeback", 32'(bad), 32'd0);
    $display("txn flush_in_run");

    // Flush in DONE has priority over completion
    i_opcode = OP_DIVU; i_dr = 4'd13; i_sr1_val = 32'd50; i_sr2_val = 32'd5;
    #1;
    for (int c = 1; c <= XLEN + 1; c++) tick();
    check("flush_done of_reg_before", 32'(o_of_reg), 32'd13);
    i_pipe_flush = 1'b1;
    #1;
    check("flush_done stall", 32'(o_pipe_stall), 32'd0);
    check("flush_done of_reg", 32'(o_of_reg), 32'd0);
    tick();
    i_pipe_flush = 1'b0;
    i_opcode     = OP_NOP;
    #1;
    check("flush_done o_dr", 32'(o_dr), 32'd0);
    check("flush_done busy", 32'(o_busy), 32'd0);
    $display("txn flush_in_done");

    // Asynchronous reset mid-RUN
    i_opcode = OP_MUL; i_dr = 4'd14; i_sr1_val = 32'd3; i_sr2_val = 32'd3;
    #1;
    for (int c = 1; c <= 5; c++) tick();
    i_opcode  = OP_ADD;
    #1;
    i_reset_n = 1'b0;
    #1;
    check("rst_run busy", 32'(o_busy), 32'd0);
    check("rst_run stall", 32'(o_pipe_stall), 32'd0);
    check("rst_run o_dr", 32'(o_dr), 32'd0);
    check("rst_run of_reg", 32'(o_of_reg), 32'd0);
    #1;
    i_reset_n = 1'b1;
    tick();
    i_dr = 4'd5;
    #1;
    check("post_rst add_stall", 32'(o_pipe_stall), 32'd0);
    tick();
    check("post_rst add_dr", 32'(o_dr), 32'd0);
    check("post_rst add_busy", 32'(o_busy), 32'd0);
    $display("txn reset_in_run");

    // Asynchronous reset during the write-back cycle clears the result immediately
    i_opcode = OP_MUL; i_dr = 4'd6; i_sr1_val = 32'd11; i_sr2_val = 32'd11;
    #1;
    for (int c = 1; c <= XLEN + 2; c++) tick();
    i_opcode = OP_NOP;
    #1;
    check("rst_wb o_dr_before", 32'(o_dr), 32'd6);
    check("rst_wb o_value_before", o_value, 32'd121);
    i_reset_n = 1'b0;
    #1;
    check("rst_wb o_dr", 32'(o_dr), 32'd0);
    check("rst_wb o_value", o_value, 32'd0);
    #1;
    i_reset_n = 1'b1;
    tick();
    $display("txn reset_in_writeback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
